// File: rtl/ave_window_stream.sv
// ---------------------------------------------------------------------------
// ave_window_stream
//
// Streaming moving-average filter over the last WIN = 2**LOG2_WIN accepted
// samples. A circular sample buffer plus a running sum (add newest, subtract
// oldest) keeps the arithmetic cost constant regardless of window length.
// Results are produced only once the window is full, with one register of
// valid/ready buffering on the output and selectable truncate / round
// half-up averaging.
//
// Vectors are declared with bit 0 as the MSB.
//
// Parameters
//   DATA_W    sample and average width (unsigned)
//   LOG2_WIN  log2 of the window length, 1..6
//
// Ports
//   CLOCK      in   1                 rising-edge clock
//   RESET_N    in   1                 asynchronous active-low reset
//   clr        in   1                 synchronous clear of window state
//   rnd_en     in   1                 1 = round half-up, 0 = truncate
//   in_data    in   DATA_W            sample
//   in_valid   in   1                 sample offered
//   in_ready   out  1                 a sample can be accepted this cycle
//   ave_data   out  DATA_W            windowed average
//   ave_valid  out  1                 ave_data holds an unconsumed result
//   ave_ready  in   1                 downstream consumes ave_data
//   fill       out  LOG2_WIN+1        samples held in the window (0..WIN)
//   sum        out  DATA_W+LOG2_WIN   running sum of the window contents
// ---------------------------------------------------------------------------
module ave_window_stream #(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 3
) (
    input  logic                         CLOCK,
    input  logic                         RESET_N,
    input  logic                         clr,
    input  logic                         rnd_en,
    input  logic [0:DATA_W-1]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [0:DATA_W-1]            ave_data,
    output logic                         ave_valid,
    input  logic                         ave_ready,
    output logic [0:LOG2_WIN]            fill,
    output logic [0:DATA_W+LOG2_WIN-1]   sum
);

    localparam int WIN   = 2 ** LOG2_WIN;
    localparam int SUM_W = DATA_W + LOG2_WIN;

    localparam logic [0:LOG2_WIN]   FILL_FULL = (LOG2_WIN + 1)'(WIN);
    localparam logic [0:LOG2_WIN]   FILL_ONE  = (LOG2_WIN + 1)'(1);
    localparam logic [0:LOG2_WIN-1] WP_ONE    = LOG2_WIN'(1);
    // Half of one LSB of the average, added before the divide for round half-up.
    localparam logic [0:SUM_W]      RND_HALF  = (SUM_W + 1)'(WIN / 2);

    logic [0:DATA_W-1]   samples [0:WIN-1];
    logic [0:LOG2_WIN-1] wp;

    logic                acc;
    logic [0:DATA_W-1]   oldest;
    logic [0:SUM_W-1]    sum_next;
    logic [0:LOG2_WIN]   fill_next;
    logic [0:SUM_W]      rnd_sum;
    logic [0:DATA_W-1]   avg_next;
    logic                full_next;

    // Single output register: a new sample may enter whenever the held result
    // is empty or is being consumed this cycle.
    assign in_ready = ~ave_valid | ave_ready;
    assign acc      = in_valid & in_ready;

    // NOTE: every signal written here gets a default value on the first lines,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        oldest    = samples[wp];
        // Unfilled entries hold 0, so subtracting the slot being overwritten is
        // exact during fill-up. Intermediate wrap is harmless: the final result
        // always fits in SUM_W bits.
        sum_next  = sum + {{LOG2_WIN{1'b0}}, in_data} - {{LOG2_WIN{1'b0}}, oldest};
        fill_next = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
        full_next = (fill_next == FILL_FULL);
        rnd_sum   = {1'b0, sum_next} + (rnd_en ? RND_HALF : '0);
        // Dropping the LOG2_WIN LSBs divides by WIN; the extra top bit is always 0
        // because the rounded average cannot exceed 2**DATA_W-1.
        avg_next  = rnd_sum[1:DATA_W];
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wp        <= '0;
            sum       <= '0;
            fill      <= '0;
            ave_data  <= '0;
            ave_valid <= 1'b0;
        end else if (clr) begin
            // Clear wins over a same-cycle accept; that sample is discarded.
            wp        <= '0;
            sum       <= '0;
            fill      <= '0;
            ave_valid <= 1'b0;
        end else begin
            if (acc) begin
                wp   <= wp + WP_ONE;
                sum  <= sum_next;
                fill <= fill_next;
            end
            // A new result replaces the held one even when it is consumed in the
            // same cycle, so ave_valid only drops on a consume without an accept.
            if (acc && full_next) begin
                ave_data  <= avg_next;
                ave_valid <= 1'b1;
            end else if (ave_ready) begin
                ave_valid <= 1'b0;
            end
        end
    end

    // NOTE: the sample buffer is reset and cleared explicitly because the
    // running-sum subtraction relies on unused slots reading as zero.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < WIN; i++) begin
                samples[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < WIN; i++) begin
                samples[i] <= '0;
            end
        end else if (acc) begin
            samples[wp] <= in_data;
        end
    end

endmodule

// File: tb/tb_ave_window_stream.sv
// ---------------------------------------------------------------------------
// tb_ave_window_stream
//
// Directed bench for ave_window_stream. Three instances share the stimulus:
// the default 8-tap window (a_*), a 2-tap window (b_*) and a 64-tap window
// (c_*). Expected values are hand-computed constants or simple closed forms.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_ave_window_stream;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        clr       = 1'b0;
    logic        rnd_en    = 1'b0;
    logic        in_valid  = 1'b0;
    logic        ave_ready = 1'b1;
    logic [0:7]  in_data   = '0;

    logic        a_in_ready, a_ave_valid;
    logic [0:7]  a_ave_data;
    logic [0:3]  a_fill;
    logic [0:10] a_sum;

    logic        b_in_ready, b_ave_valid;
    logic [0:7]  b_ave_data;
    logic [0:1]  b_fill;
    logic [0:8]  b_sum;

    logic        c_in_ready, c_ave_valid;
    logic [0:7]  c_ave_data;
    logic [0:6]  c_fill;
    logic [0:13] c_sum;

    int n_checks = 0;
    int n_pass   = 0;

    ave_window_stream #(.DATA_W(8), .LOG2_WIN(3)) dut_a (
        .CLOCK(clk), .RESET_N(rst_n), .clr(clr), .rnd_en(rnd_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .ave_data(a_ave_data), .ave_valid(a_ave_valid), .ave_ready(ave_ready),
        .fill(a_fill), .sum(a_sum)
    );

    ave_window_stream #(.DATA_W(8), .LOG2_WIN(1)) dut_b (
        .CLOCK(clk), .RESET_N(rst_n), .clr(clr), .rnd_en(rnd_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .ave_data(b_ave_data), .ave_valid(b_ave_valid), .ave_ready(ave_ready),
        .fill(b_fill), .sum(b_sum)
    );

    ave_window_stream #(.DATA_W(8), .LOG2_WIN(6)) dut_c (
        .CLOCK(clk), .RESET_N(rst_n), .clr(clr), .rnd_en(rnd_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(c_in_ready),
        .ave_data(c_ave_data), .ave_valid(c_ave_valid), .ave_ready(ave_ready),
        .fill(c_fill), .sum(c_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [0:7] pat [0:7];

        // ---------------- reset state ----------------
        #2;
        check("rst_valid",    32'(a_ave_valid), 32'd0);
        check("rst_data",     32'(a_ave_data),  32'd0);
        check("rst_fill",     32'(a_fill),      32'd0);
        check("rst_sum",      32'(a_sum),       32'd0);
        check("rst_in_ready", 32'(a_in_ready),  32'd1);
        rst_n = 1'b1;

        // ---------------- test 1: 8 x 10 ----------------
        ave_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd10;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (k < 8) begin
                check("t1_valid_low", 32'(a_ave_valid), 32'd0);
                check("t1_fill",      32'(a_fill),      32'(k));
            end
        end
        check("t1_valid", 32'(a_ave_valid), 32'd1);
        check("t1_data",  32'(a_ave_data),  32'd10);
        check("t1_fill8", 32'(a_fill),      32'd8);
        check("t1_sum",   32'(a_sum),       32'd80);
        in_valid = 1'b0;
        tick;
        check("t1_consumed", 32'(a_ave_valid), 32'd0);

        // ---------------- test 2: ramp 1..12 ----------------
        do_reset;
        in_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            in_data = 8'(k);
            tick;
            if (k < 8) begin
                check("t2_valid_low", 32'(a_ave_valid), 32'd0);
            end else begin
                check("t2_valid", 32'(a_ave_valid), 32'd1);
                check("t2_sum",   32'(a_sum),       32'(8 * k - 28));
                check("t2_data",  32'(a_ave_data),  32'((8 * k - 28) / 8));
            end
        end
        check("t2_fill", 32'(a_fill), 32'd8);

        // ---------------- test 3: rounding ----------------
        do_reset;
        pat = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd4, 8'd4, 8'd0, 8'd0};
        rnd_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_data = pat[k];
            tick;
        end
        check("t3_trunc_data", 32'(a_ave_data), 32'd1);
        check("t3_trunc_sum",  32'(a_sum),      32'd12);
        // Replacing the oldest 1 with another 1 keeps the sum at 12.
        rnd_en  = 1'b1;
        in_data = 8'd1;
        tick;
        check("t3_round_data", 32'(a_ave_data), 32'd2);
        check("t3_round_sum",  32'(a_sum),      32'd12);
        in_valid = 1'b0;
        rnd_en   = 1'b0;
        tick;
        check("t3_held_data", 32'(a_ave_data), 32'd2);
        check("t3_consumed",  32'(a_ave_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'd255;
        for (int k = 0; k < 8; k++) tick;
        check("t3_max_trunc", 32'(a_ave_data), 32'd255);
        check("t3_max_sum",   32'(a_sum),      32'd2040);
        rnd_en = 1'b1;
        tick;
        check("t3_max_round",     32'(a_ave_data), 32'd255);
        check("t3_max_round_sum", 32'(a_sum),      32'd2040);

        // ---------------- test 4: backpressure ----------------
        rnd_en    = 1'b0;
        ave_ready = 1'b0;
        in_valid  = 1'b0;
        tick;
        check("t4_valid_held", 32'(a_ave_valid), 32'd1);
        check("t4_in_ready",   32'(a_in_ready),  32'd0);
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int k = 0; k < 3; k++) tick;
        check("t4_fill_held", 32'(a_fill),      32'd8);
        check("t4_sum_held",  32'(a_sum),       32'd2040);
        check("t4_data_held", 32'(a_ave_data),  32'd255);
        check("t4_valid",     32'(a_ave_valid), 32'd1);
        ave_ready = 1'b1;
        #1;
        check("t4_in_ready_up", 32'(a_in_ready), 32'd1);
        tick;
        check("t4_new_sum",   32'(a_sum),       32'd1792);
        check("t4_new_data",  32'(a_ave_data),  32'd224);
        check("t4_new_valid", 32'(a_ave_valid), 32'd1);
        in_valid = 1'b0;
        tick;
        check("t4_drained", 32'(a_ave_valid), 32'd0);

        // ---------------- test 5: clear ----------------
        do_reset;
        in_valid = 1'b1;
        in_data  = 8'd100;
        for (int k = 0; k < 5; k++) tick;
        check("t5_fill5", 32'(a_fill), 32'd5);
        clr     = 1'b1;
        in_data = 8'd50;
        tick;
        clr = 1'b0;
        check("t5_clr_fill",  32'(a_fill),      32'd0);
        check("t5_clr_sum",   32'(a_sum),       32'd0);
        check("t5_clr_valid", 32'(a_ave_valid), 32'd0);
        in_data = 8'd3;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (k == 7) begin
                check("t5_fill7",   32'(a_fill),      32'd7);
                check("t5_valid_7", 32'(a_ave_valid), 32'd0);
            end
        end
        check("t5_data",  32'(a_ave_data),  32'd3);
        check("t5_sum",   32'(a_sum),       32'd24);
        check("t5_valid", 32'(a_ave_valid), 32'd1);

        // ---------------- test 6: async reset mid-stream ----------------
        in_valid  = 1'b0;
        ave_ready = 1'b0;
        tick;
        check("t6_pending", 32'(a_ave_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",    32'(a_ave_valid), 32'd0);
        check("t6_rst_data",     32'(a_ave_data),  32'd0);
        check("t6_rst_fill",     32'(a_fill),      32'd0);
        check("t6_rst_sum",      32'(a_sum),       32'd0);
        check("t6_rst_in_ready", 32'(a_in_ready),  32'd1);
        rst_n = 1'b1;

        // ---------------- test 1 repeated at WIN=2 and WIN=64 ----------------
        ave_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd10;
        for (int k = 1; k <= 64; k++) begin
            tick;
            if (k == 1) begin
                check("w2_valid_low", 32'(b_ave_valid), 32'd0);
            end
            if (k == 2) begin
                check("w2_valid", 32'(b_ave_valid), 32'd1);
                check("w2_data",  32'(b_ave_data),  32'd10);
                check("w2_sum",   32'(b_sum),       32'd20);
                check("w2_fill",  32'(b_fill),      32'd2);
            end
            if (k == 63) begin
                check("w64_valid_low", 32'(c_ave_valid), 32'd0);
                check("w64_fill63",    32'(c_fill),      32'd63);
            end
        end
        check("w64_valid", 32'(c_ave_valid), 32'd1);
        check("w64_data",  32'(c_ave_data),  32'd10);
        check("w64_sum",   32'(c_sum),       32'd640);
        check("w64_fill",  32'(c_fill),      32'd64);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
